approx_mac_accum: RTL and testbench
===================================

# approx_mac_accum

Streaming accumulator that sits directly downstream of the 16x16 approximate multiplier. It sums a frame of signed 32-bit products into a wide saturating accumulator and presents one result per frame. Both ends use a valid/ready handshake. Typical use is dot-product and filter-tap reduction on approximate products.

## Interface
- ACC_W, 40: accumulator and result width in bits; legal range 33..64.
- LEN_W, 8: width of the frame-length field.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- frame_len  in  LEN_W  number of products in the frame; sampled when start is honoured.
- in_prod  in  32  signed two's-complement product from the multiplier.
- in_valid  in  1  in_prod is valid.
- in_ready  out  1  block accepts in_prod this cycle.
- out_acc  out  ACC_W  signed frame sum.
- out_sat  out  1  the frame saturated at least once.
- out_valid  out  1  out_acc and out_sat are valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, ACC, HOLD.
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE;
  - acc, cnt, len, sat and every output are cleared to 0.
- IDLE:
  - in_ready=0 and out_valid=0.
  - start with frame_len≠0: latch len=frame_len, clear acc, cnt and sat, then go to ACC.
  - start with frame_len=0: clear acc and sat, then go to HOLD, giving a zero result.
- ACC:
  - in_ready=1.
  - A transfer is a cycle with in_valid && in_ready. On each transfer:
    - acc ← sat(acc + sext(in_prod));
    - cnt ← cnt+1.
  - The transfer with cnt==len-1 is the last one; go to HOLD.
  - Cycles with in_valid=0 leave all state unchanged.
- HOLD:
  - out_valid=1; out_acc=acc and out_sat=sat, both stable.
  - in_ready=0.
  - When out_valid && out_ready: go to IDLE.
- Arithmetic:
  - in_prod is sign-extended to ACC_W+1 bits and added to acc, also sign-extended to ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1 it clamps to that value and sets sat.
  - If the result is below -2^(ACC_W-1) it clamps to that value and sets sat.
  - sat is sticky for the frame.
- Simultaneous and boundary events:
  - start is ignored in ACC and HOLD. No queuing.
  - start in the same cycle as the HOLD→IDLE handshake is ignored. A new frame needs start in IDLE.
  - frame_len changes after the latch do not affect the current frame.
  - len=2^LEN_W-1 is legal; cnt must not wrap before the last transfer.
  - A product that lands exactly on a saturation bound does not set sat.
- Reset mid-frame: the frame is abandoned with no out_valid, and the next cycle is IDLE.

## Timing
- start in IDLE at cycle T: in_ready=1 from T+1.
- Last transfer at cycle T: out_valid=1 from T+1, with out_acc already containing that product.
- Throughput in ACC: one product per cycle.
- Minimum frame turnaround:
  - len cycles in ACC;
  - at least 1 cycle in HOLD;
  - 1 cycle in IDLE before start.
- frame_len=0: out_valid at T+1 after start.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Package approx_mac_pkg holds:
  - the state enum: IDLE, ACC, HOLD;
  - the product width constant PROD_W=32;
  - sat_max(ACC_W) and sat_min(ACC_W) constant functions.
- One sub-module, sat_add.
  - Parameter ACC_W.
  - Combinational signed add of acc and the sign-extended product.
  - Outputs the clamped sum and an overflow flag.
  - Reusable by later reduction stages.

## Test plan
- Basic sum: frame_len=4, products 10, -3, 100, 7 back-to-back → out_acc=114 and out_sat=0, one cycle after the 4th transfer.
- Upstream gaps and downstream backpressure: frame_len=3, products -5, -5, -5 with in_valid low for 2 cycles between products, and out_ready held low for 5 cycles → out_acc=-15 held stable while waiting, then IDLE one cycle after the handshake.
- Saturation: ACC_W=33, frame_len=3, product 0x7FFFFFFF ×3 → out_acc=2^32-1 and out_sat=1. A following frame of 1 and 2 → out_acc=3 and out_sat=0.
- Zero-length frame: frame_len=0 → out_valid one cycle after start with out_acc=0, and in_ready never high.
- Reset mid-frame: frame_len=8, rst_n=0 after 3 transfers → all outputs 0 and no out_valid. A subsequent frame_len=2 with 1, 1 → out_acc=2.
- Ignored start: start pulsed during ACC and during HOLD → no effect on the result, and the next frame begins only on a start in IDLE.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate-product MAC reduction path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package approx_mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int PROD_W = 32;

   // Largest signed value representable in acc_w bits (acc_w <= 64).
   function automatic logic signed [63:0] sat_max(input int acc_w);
      return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
   endfunction

   // Smallest signed value representable in acc_w bits (acc_w <= 64).
   function automatic logic signed [63:0] sat_min(input int acc_w);
      return -(64'sd1 <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/approx_mac_accum_sat_add.sv
// Saturating signed add of a wide accumulator and a sign-extended product.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module sat_add
   import approx_mac_pkg::*;
#(
   parameter int ACC_W = 40
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [PROD_W-1:0] prod,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     ovf
);

   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

   logic signed [ACC_W:0] wide;

   // One guard bit: the two top bits disagree exactly when the true sum leaves the ACC_W range.
   always_comb begin
      wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
      ovf  = wide[ACC_W] ^ wide[ACC_W-1];
      sum  = wide[ACC_W-1:0];
      if (ovf) begin
         sum = wide[ACC_W] ? MIN_V : MAX_V;
      end
   end

endmodule

// File: rtl/approx_mac_accum.sv
// Frame accumulator: sums frame_len signed products into a saturating ACC_W-bit result.
// Latency: result valid the cycle after the last accepted product (after start for empty frames).
// Backpressure: in_ready only in ACC; result held stable in HOLD until out_ready.
module approx_mac_accum
   import approx_mac_pkg::*;
#(
   parameter int ACC_W = 40,
   parameter int LEN_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [LEN_W-1:0]        frame_len,
   input  logic [PROD_W-1:0]       in_prod,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [ACC_W-1:0]        out_acc,
   output logic                    out_sat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   state_t            state;
   state_t            state_nxt;
   logic [ACC_W-1:0]  acc;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  len;
   logic              sat;
   logic [ACC_W-1:0]  acc_sum;
   logic              acc_ovf;
   logic              last_xfer;

   // cnt only reaches len-1, so len = 2^LEN_W-1 never needs a wrap before the final product.
   assign last_xfer = (cnt == len - LEN_W'(1));

   sat_add #(
      .ACC_W (ACC_W)
   ) u_sat_add (
      .acc  (acc),
      .prod (in_prod),
      .sum  (acc_sum),
      .ovf  (acc_ovf)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; handshake outputs decode from state only.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = (frame_len != '0) ? ACC : HOLD;
            end
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && last_xfer) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy      = 1'b0;
         end
      endcase
   end

   // Accumulator, counter, latched length and sticky saturation flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         len <= '0;
         sat <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  sat <= 1'b0;
                  if (frame_len != '0) begin
                     len <= frame_len;
                     cnt <= '0;
                  end
               end
            end
            ACC: begin
               if (in_valid) begin
                  acc <= acc_sum;
                  sat <= sat | acc_ovf;
                  cnt <= cnt + LEN_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_acc = acc;
   assign out_sat = sat;

endmodule

// File: tb/tb_approx_mac_accum.sv
// Self-checking bench for approx_mac_accum with a frame-level reference model.
// Latency: checks result one cycle after the last product.
// Backpressure: exercises upstream gaps and held-off out_ready.
module tb_approx_mac_accum;

   localparam int AW = 33;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] frame_len = '0;
   logic [31:0]   in_prod = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] out_acc;
   logic          out_sat;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;

   int tests = 0;
   int fails = 0;
   logic [31:0] prods[$];

   approx_mac_accum #(.ACC_W(AW), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame_len (frame_len),
      .in_prod   (in_prod),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_acc   (out_acc),
      .out_sat   (out_sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: running sum with per-step clamping to the signed AW-bit range.
   function automatic void model(output longint s, output bit sf);
      longint mx = (longint'(1) <<< (AW - 1)) - 1;
      longint mn = -mx - 1;
      s  = 0;
      sf = 1'b0;
      foreach (prods[i]) begin
         s = s + longint'($signed(prods[i]));
         if (s > mx) begin
            s = mx; sf = 1'b1;
         end else if (s < mn) begin
            s = mn; sf = 1'b1;
         end
      end
   endfunction

   // Starts a frame and streams prods; gap < 0 picks random idle cycles between products.
   task automatic drive_frame(input int n, input int gap, output int to);
      int k;
      int g;
      to = 0;
      start = 1'b1;
      frame_len = LW'(n);
      tick();
      start = 1'b0;
      frame_len = LW'($urandom);
      foreach (prods[i]) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         if (i > 0) begin
            repeat (g) begin
               in_valid = 1'b0;
               tick();
            end
         end
         in_valid = 1'b1;
         in_prod = prods[i];
         k = 0;
         while (in_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
         end
         if (k >= 50) to++;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (out_acc !== '0) begin fails++; $display("FAIL reset_out_acc got %h want 0", out_acc); end
      tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int to;
      prods = '{32'd10, -32'sd3, 32'd100, 32'd7};
      drive_frame(4, 0, to);
      tests++; if (to != 0) begin fails++; $display("FAIL basic_in_ready_timeout got %0d want 0", to); end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
      tests++; if (out_acc !== AW'(114)) begin fails++; $display("FAIL basic_out_acc got %0d want 114", $signed(out_acc)); end
      tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL basic_out_sat got %b want 0", out_sat); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_hold_in_ready got %b want 0", in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_idle got busy=%b valid=%b want 0 0", busy, out_valid); end
   endtask

   task automatic test_gaps_backpressure();
      int to;
      prods = '{-32'sd5, -32'sd5, -32'sd5};
      drive_frame(3, 2, to);
      tests++; if (to != 0) begin fails++; $display("FAIL gaps_in_ready_timeout got %0d want 0", to); end
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (out_valid !== 1'b1 || out_acc !== AW'(-15)) begin
            fails++; $display("FAIL gaps_hold_stable cyc %0d got valid=%b acc=%0d want 1 -15", c, out_valid, $signed(out_acc));
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL gaps_idle got busy=%b valid=%b want 0 0", busy, out_valid); end
   endtask

   task automatic test_saturation();
      int to;
      prods = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      drive_frame(3, 0, to);
      tests++; if (out_valid !== 1'b1 || out_acc !== 33'h0_FFFF_FFFF || out_sat !== 1'b1) begin
         fails++; $display("FAIL sat_pos got valid=%b acc=%h sat=%b want 1 0ffffffff 1", out_valid, out_acc, out_sat); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      prods = '{32'd1, 32'd2};
      drive_frame(2, 0, to);
      tests++; if (out_acc !== AW'(3) || out_sat !== 1'b0) begin
         fails++; $display("FAIL sat_cleared got acc=%0d sat=%b want 3 0", $signed(out_acc), out_sat); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      prods = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1};
      drive_frame(3, 0, to);
      tests++; if (out_acc !== 33'h0_FFFF_FFFF || out_sat !== 1'b0) begin
         fails++; $display("FAIL sat_exact_max got acc=%h sat=%b want 0ffffffff 0", out_acc, out_sat); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      prods = '{32'h8000_0000, 32'h8000_0000};
      drive_frame(2, 0, to);
      tests++; if (out_acc !== 33'h1_0000_0000 || out_sat !== 1'b0) begin
         fails++; $display("FAIL sat_exact_min got acc=%h sat=%b want 100000000 0", out_acc, out_sat); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      prods = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd4};
      drive_frame(4, 0, to);
      tests++; if (out_acc !== 33'h1_0000_0004 || out_sat !== 1'b1) begin
         fails++; $display("FAIL sat_neg_sticky got acc=%h sat=%b want 100000004 1", out_acc, out_sat); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_zero_len();
      start = 1'b1;
      frame_len = '0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tests++;
         if (out_valid !== 1'b1 || out_acc !== '0 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL zero_len cyc %0d got valid=%b acc=%h sat=%b rdy=%b want 1 0 0 0", c, out_valid, out_acc, out_sat, in_ready);
         end
         tick();
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int to;
      start = 1'b1;
      frame_len = LW'(8);
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_prod = 32'd100;
      repeat (3) tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      tests++; if (out_valid !== 1'b0 || out_acc !== '0 || out_sat !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL midreset_outputs got valid=%b acc=%h sat=%b rdy=%b busy=%b want all 0", out_valid, out_acc, out_sat, in_ready, busy); end
      rst_n = 1'b1;
      tick();
      tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL midreset_idle got busy=%b valid=%b want 0 0", busy, out_valid); end
      prods = '{32'd1, 32'd1};
      drive_frame(2, 0, to);
      tests++; if (out_valid !== 1'b1 || out_acc !== AW'(2)) begin
         fails++; $display("FAIL midreset_next got valid=%b acc=%0d want 1 2", out_valid, $signed(out_acc)); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_ignored_start();
      int to;
      start = 1'b1;
      frame_len = LW'(3);
      tick();
      in_valid = 1'b1;
      in_prod = 32'd1;
      start = 1'b1;
      frame_len = LW'(1);
      tick();
      start = 1'b0;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL ign_start_acc got valid=%b rdy=%b want 0 1", out_valid, in_ready); end
      in_prod = 32'd2;
      tick();
      in_prod = 32'd3;
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1 || out_acc !== AW'(6)) begin fails++; $display("FAIL ign_start_result got valid=%b acc=%0d want 1 6", out_valid, $signed(out_acc)); end
      start = 1'b1;
      frame_len = LW'(5);
      tick();
      start = 1'b0;
      tests++; if (out_valid !== 1'b1 || out_acc !== AW'(6)) begin fails++; $display("FAIL ign_start_hold got valid=%b acc=%0d want 1 6", out_valid, $signed(out_acc)); end
      start = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_start_handshake got busy=%b want 0", busy); end
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_start_no_queue got busy=%b want 0", busy); end
      prods = '{32'd4};
      drive_frame(1, 0, to);
      tests++; if (out_valid !== 1'b1 || out_acc !== AW'(4)) begin fails++; $display("FAIL ign_start_next got valid=%b acc=%0d want 1 4", out_valid, $signed(out_acc)); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_random();
      int to;
      int n;
      int d;
      int r;
      int v;
      longint s;
      bit sf;
      for (int f = 0; f < 12; f++) begin
         n = (f == 0) ? 255 : int'($urandom_range(1, 12));
         prods.delete();
         for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 4));
            v = int'($urandom_range(0, 2000)) - 1000;
            case (r)
               0: prods.push_back(32'h7FFF_FFFF);
               1: prods.push_back(32'h8000_0000);
               2: prods.push_back($urandom);
               default: prods.push_back(32'(v));
            endcase
         end
         model(s, sf);
         drive_frame(n, -1, to);
         tests++; if (to != 0) begin fails++; $display("FAIL rand_timeout frame %0d got %0d want 0", f, to); end
         tests++; if (out_valid !== 1'b1 || out_acc !== AW'(s) || out_sat !== sf) begin
            fails++; $display("FAIL rand_result frame %0d len %0d got valid=%b acc=%h sat=%b want 1 %h %b", f, n, out_valid, out_acc, out_sat, AW'(s), sf); end
         d = int'($urandom_range(0, 3));
         for (int c = 0; c < d; c++) begin
            tick();
            tests++; if (out_valid !== 1'b1 || out_acc !== AW'(s)) begin
               fails++; $display("FAIL rand_hold frame %0d got valid=%b acc=%h want 1 %h", f, out_valid, out_acc, AW'(s)); end
         end
         out_ready = 1'b1; tick(); out_ready = 1'b0;
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rand_idle frame %0d got busy=%b want 0", f, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps_backpressure();
      test_saturation();
      test_zero_len();
      test_reset_midframe();
      test_ignored_start();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
